// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the 3-operand ALU datapath.
// Loads a, b, c and op one word at a time from a valid/ready stream and holds
// them on registers for the ALU. After one settle cycle it captures the ALU
// result, offers it downstream with a valid/ready handshake, and counts each
// delivered result.
module alu_operand_sequencer #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] op,
  input  logic [WIDTH-1:0] r_in,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] res_cnt
);

  typedef enum logic [2:0] {
    LD_A  = 3'd0,
    LD_B  = 3'd1,
    LD_C  = 3'd2,
    LD_OP = 3'd3,
    EVAL  = 3'd4,
    HOLD  = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  // A word is taken only while loading, and never in a cycle that clear aborts.
  logic xfer;

  assign in_ready = (state == LD_A) || (state == LD_B) ||
                    (state == LD_C) || (state == LD_OP);
  assign busy     = (state != LD_A);
  assign xfer     = in_valid & in_ready & ~clear;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LD_A;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: clear overrides every handshake.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = LD_A;
    end else begin
      case (state)
        LD_A:    if (in_valid) state_next = LD_B;
        LD_B:    if (in_valid) state_next = LD_C;
        LD_C:    if (in_valid) state_next = LD_OP;
        LD_OP:   if (in_valid) state_next = EVAL;
        EVAL:    state_next = HOLD;
        HOLD:    if (res_ready) state_next = LD_A;
        default: state_next = LD_A;
      endcase
    end
  end

  // Operand, result and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= '0;
      b         <= '0;
      c         <= '0;
      op        <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      res_cnt   <= '0;
    end else if (clear) begin
      // Abort: operands and any pending result are dropped, but the last
      // delivered result and the delivery count survive.
      a         <= '0;
      b         <= '0;
      c         <= '0;
      op        <= '0;
      res_valid <= 1'b0;
    end else begin
      if (xfer) begin
        case (state)
          LD_A:    a  <= in_data;
          LD_B:    b  <= in_data;
          LD_C:    c  <= in_data;
          LD_OP:   op <= in_data;
          default: ;
        endcase
      end
      // Operands have been stable for the whole EVAL cycle; sample the ALU.
      if (state == EVAL) begin
        res       <= r_in;
        res_valid <= 1'b1;
      end
      if ((state == HOLD) && res_ready) begin
        res_valid <= 1'b0;
        res_cnt   <= res_cnt + 1'b1;
      end
    end
  end

endmodule
